// File: rtl/cgra_cfg_pkg.sv
// Shared constants and FSM state type for the bitstream-domain
// configuration loader.
package cgra_cfg_pkg;

   localparam int WORDS_PER_PE = 3;
   localparam int CFG_WIDTH    = 96;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CATCH,
      CHECK,
      DONE
   } cfg_state_t;

endpackage

// File: rtl/cfg_word_assembler.sv
// Stages incoming words for one PE and flags the transfer that
// completes the configuration.
module cfg_word_assembler #(
   parameter int WORD_WIDTH = 32,
   parameter int CFG_WIDTH  = cgra_cfg_pkg::CFG_WIDTH
) (
   input  logic                  clk_bs,
   input  logic                  rst_bs,
   input  logic                  clr_i,
   input  logic                  we_i,
   input  logic [WORD_WIDTH-1:0] word_i,
   output logic                  complete_o,
   output logic [CFG_WIDTH-1:0]  cfg_o
);
   import cgra_cfg_pkg::*;

   localparam int            SW   = CFG_WIDTH - WORD_WIDTH;
   localparam logic [1:0]    LAST = 2'(WORDS_PER_PE - 1);

   logic [1:0]    cnt_q;
   logic [SW-1:0] stage_q;

   assign complete_o = we_i && (cnt_q == LAST);
   // The final word is merged directly, so it never needs staging.
   assign cfg_o      = {word_i, stage_q};

   always_ff @(posedge clk_bs or posedge rst_bs) begin
      if (rst_bs) begin
         cnt_q   <= '0;
         stage_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (we_i) begin
         for (int i = 0; i < WORDS_PER_PE - 1; i++) begin
            if (cnt_q == 2'(i))
               stage_q[i*WORD_WIDTH +: WORD_WIDTH] <= word_i;
         end
         cnt_q <= complete_o ? 2'd0 : cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/cgra_config_loader.sv
// Loads per-PE configs in index order and strobes catch_config.
// Optional trailing checksum word: define CGRA_CFG_CHECKSUM_EN.
module cgra_config_loader #(
   parameter int NUM_PE     = 16,
   parameter int WORD_WIDTH = 32,
   parameter int CFG_WIDTH  = cgra_cfg_pkg::CFG_WIDTH
) (
   input  logic                  clk_bs,
   input  logic                  rst_bs,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] cfg_word,
   input  logic                  cfg_word_v,
   output logic                  cfg_word_r,
   output logic [CFG_WIDTH-1:0]  config_bits,
   output logic [NUM_PE-1:0]     catch_config,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   import cgra_cfg_pkg::*;

   localparam int            PW      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [PW-1:0] LAST_PE = PW'(NUM_PE - 1);

   cfg_state_t           state_q;
   logic [PW-1:0]        pe_idx_q;
   logic [CFG_WIDTH-1:0] bits_q;
   logic [NUM_PE-1:0]    catch_q;
   logic                 busy_q;
   logic                 done_q;

   logic                 xfer;
   logic                 asm_we;
   logic                 asm_clr;
   logic                 asm_done;
   logic [CFG_WIDTH-1:0] asm_cfg;

`ifdef CGRA_CFG_CHECKSUM_EN
   assign cfg_word_r = (state_q == LOAD) || (state_q == CHECK);
`else
   assign cfg_word_r = (state_q == LOAD);
`endif

   assign xfer    = cfg_word_v && cfg_word_r;
   assign asm_we  = xfer && (state_q == LOAD);
   assign asm_clr = (state_q == IDLE) && start;

   cfg_word_assembler #(
      .WORD_WIDTH (WORD_WIDTH),
      .CFG_WIDTH  (CFG_WIDTH)
   ) u_asm (
      .clk_bs     (clk_bs),
      .rst_bs     (rst_bs),
      .clr_i      (asm_clr),
      .we_i       (asm_we),
      .word_i     (cfg_word),
      .complete_o (asm_done),
      .cfg_o      (asm_cfg)
   );

   always_ff @(posedge clk_bs or posedge rst_bs) begin
      if (rst_bs) begin
         state_q  <= IDLE;
         pe_idx_q <= '0;
         bits_q   <= '0;
         catch_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (start) begin
               state_q  <= LOAD;
               pe_idx_q <= '0;
               busy_q   <= 1'b1;
            end
            LOAD: if (asm_done) begin
               bits_q  <= asm_cfg;
               catch_q <= NUM_PE'(1) << pe_idx_q;
               state_q <= CATCH;
            end
            CATCH: begin
               catch_q <= '0;
               if (pe_idx_q == LAST_PE) begin
`ifdef CGRA_CFG_CHECKSUM_EN
                  state_q <= CHECK;
`else
                  state_q <= DONE;
                  done_q  <= 1'b1;
`endif
               end else begin
                  pe_idx_q <= pe_idx_q + 1'b1;
                  state_q  <= LOAD;
               end
            end
            CHECK: if (xfer) begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CGRA_CFG_CHECKSUM_EN
   logic [WORD_WIDTH-1:0] csum_q;
   logic                  error_q;

   // Loaded PEs stay loaded on a mismatch; error only flags it.
   always_ff @(posedge clk_bs or posedge rst_bs) begin
      if (rst_bs) begin
         csum_q  <= '0;
         error_q <= 1'b0;
      end else if (asm_clr) begin
         csum_q  <= '0;
         error_q <= 1'b0;
      end else if (asm_we) begin
         csum_q <= csum_q ^ cfg_word;
      end else if (xfer && state_q == CHECK) begin
         error_q <= (cfg_word != csum_q);
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign config_bits  = bits_q;
   assign catch_config = catch_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Randomized bench for cgra_config_loader against a word-list model
// of the expected per-PE configurations and catch order.
module tb_cgra_config_loader;

   localparam int NPE = 4;
   localparam int CW  = 96;
   localparam int TO  = 40;

   logic            clk_bs = 1'b0;
   logic            rst_bs = 1'b0;
   logic            start = 1'b0;
   logic [31:0]     cfg_word = '0;
   logic            cfg_word_v = 1'b0;
   logic            cfg_word_r;
   logic [CW-1:0]   config_bits;
   logic [NPE-1:0]  catch_config;
   logic            busy;
   logic            done;
   logic            error;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int xfer_cnt = 0;
   int last_xfer_cyc = -1;
   int last_catch_cyc = -1;
   int multi_err = 0;
   int rdy_err = 0;
   int lat_err = 0;

   logic [NPE-1:0] q_catch[$];
   logic [CW-1:0]  q_bits[$];
   int             q_xfer[$];
   logic [31:0]    wq[$];

   always #5 clk_bs = ~clk_bs;

   cgra_config_loader #(.NUM_PE(NPE)) dut (
      .clk_bs       (clk_bs),
      .rst_bs       (rst_bs),
      .start        (start),
      .cfg_word     (cfg_word),
      .cfg_word_v   (cfg_word_v),
      .cfg_word_r   (cfg_word_r),
      .config_bits  (config_bits),
      .catch_config (catch_config),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   task automatic chk(input string tag, input logic [CW-1:0] act,
                      input logic [CW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   always @(posedge clk_bs) begin
      cyc <= cyc + 1;
      if (cfg_word_v && cfg_word_r && !rst_bs) begin
         xfer_cnt      <= xfer_cnt + 1;
         last_xfer_cyc <= cyc + 1;
      end
   end

   always @(negedge clk_bs) begin
      if (catch_config != '0) begin
         q_catch.push_back(catch_config);
         q_bits.push_back(config_bits);
         q_xfer.push_back(xfer_cnt);
         if (last_xfer_cyc != cyc) lat_err <= lat_err + 1;
         if (cfg_word_r) rdy_err <= rdy_err + 1;
         last_catch_cyc <= cyc;
      end
      if ($countones(catch_config) > 1) multi_err <= multi_err + 1;
   end

   task automatic send_word(input logic [31:0] w);
      int n;
      n = 0;
      cfg_word   = w;
      cfg_word_v = 1'b1;
      while (!cfg_word_r && n < TO) begin
         @(negedge clk_bs);
         n++;
      end
      chk("ready_wait", CW'(n < TO), CW'(1));
      @(negedge clk_bs);
      cfg_word_v = 1'b0;
   endtask

   task automatic fill_random();
      wq.delete();
      for (int i = 0; i < 3 * NPE; i++) wq.push_back($urandom);
   endtask

   task automatic run_load(input int stall_mode, input bit mid_start,
                           input bit bad_sum);
      int          cb;
      int          xb;
      int          n;
      int          st;
      bit          exp_err;
      logic [31:0] sum;
      logic [NPE-1:0] oh;
      cb = q_catch.size();
      xb = xfer_cnt;
      exp_err = 1'b0;
      @(negedge clk_bs);
      start = 1'b1;
      @(negedge clk_bs);
      start = 1'b0;
      chk("busy_on", CW'(busy), CW'(1));
      chk("err_clr", CW'(error), CW'(0));
      for (int i = 0; i < wq.size(); i++) begin
         st = (stall_mode == 0) ? 0 :
              (stall_mode == 1) ? ((i % 2 == 1) ? 2 : 0) :
              int'($urandom_range(0, 3));
         repeat (st) @(negedge clk_bs);
         if (mid_start && i == 4) start = 1'b1;
         send_word(wq[i]);
         start = 1'b0;
      end
`ifdef CGRA_CFG_CHECKSUM_EN
      sum = '0;
      foreach (wq[i]) sum ^= wq[i];
      exp_err = bad_sum;
      send_word(bad_sum ? (sum ^ 32'h1) : sum);
`else
      sum = '0;
      if (bad_sum) exp_err = 1'b0;
`endif
      n = 0;
      while (!done && n < TO) begin
         @(negedge clk_bs);
         n++;
      end
      chk("done_seen", CW'(done), CW'(1));
`ifndef CGRA_CFG_CHECKSUM_EN
      chk("done_lat", CW'(cyc - last_catch_cyc), CW'(1));
`endif
      chk("error", CW'(error), CW'(exp_err));
      @(negedge clk_bs);
      chk("done_pulse", CW'(done), CW'(0));
      chk("busy_off", CW'(busy), CW'(0));
      chk("n_catch", CW'(q_catch.size() - cb), CW'(NPE));
      for (int k = 0; k < NPE && cb + k < q_catch.size(); k++) begin
         oh = '0;
         oh[k] = 1'b1;
         chk("catch_pe", CW'(q_catch[cb+k]), CW'(oh));
         chk("cfg_bits", q_bits[cb+k], {wq[3*k+2], wq[3*k+1], wq[3*k]});
         chk("words_at_catch", CW'(q_xfer[cb+k] - xb), CW'(3 * (k + 1)));
      end
      chk("bits_held", config_bits,
          {wq[3*NPE-1], wq[3*NPE-2], wq[3*NPE-3]});
      chk("multihot", CW'(multi_err), CW'(0));
      chk("rdy_in_catch", CW'(rdy_err), CW'(0));
      chk("catch_lat", CW'(lat_err), CW'(0));
   endtask

   initial begin
      int cb;
      int xb;
      #1 rst_bs = 1'b1;
      #2;
      chk("rst_bits", config_bits, CW'(0));
      chk("rst_catch", CW'(catch_config), CW'(0));
      chk("rst_rdy", CW'(cfg_word_r), CW'(0));
      chk("rst_busy", CW'(busy), CW'(0));
      chk("rst_done", CW'(done), CW'(0));
      chk("rst_err", CW'(error), CW'(0));
      repeat (2) @(negedge clk_bs);
      rst_bs = 1'b0;

      wq.delete();
      for (int i = 0; i < 3 * NPE; i++) wq.push_back(32'(i + 1));
      run_load(0, 1'b0, 1'b0);
      run_load(1, 1'b0, 1'b0);

      cb = q_catch.size();
      xb = xfer_cnt;
      cfg_word   = 32'hDEAD_BEEF;
      cfg_word_v = 1'b1;
      repeat (5) @(negedge clk_bs);
      chk("idle_rdy", CW'(cfg_word_r), CW'(0));
      chk("idle_busy", CW'(busy), CW'(0));
      chk("idle_xfer", CW'(xfer_cnt - xb), CW'(0));
      chk("idle_catch", CW'(q_catch.size() - cb), CW'(0));
      cfg_word_v = 1'b0;

      fill_random();
      run_load(2, 1'b1, 1'b0);

      fill_random();
      @(negedge clk_bs);
      start = 1'b1;
      @(negedge clk_bs);
      start = 1'b0;
      for (int i = 0; i < 5; i++) send_word(wq[i]);
      #2 rst_bs = 1'b1;
      #1;
      chk("arst_bits", config_bits, CW'(0));
      chk("arst_catch", CW'(catch_config), CW'(0));
      chk("arst_rdy", CW'(cfg_word_r), CW'(0));
      chk("arst_busy", CW'(busy), CW'(0));
      @(negedge clk_bs);
      rst_bs = 1'b0;
      fill_random();
      run_load(0, 1'b0, 1'b0);

      fill_random();
      run_load(2, 1'b0, 1'b1);
      repeat (3) @(negedge clk_bs);
`ifdef CGRA_CFG_CHECKSUM_EN
      chk("err_sticky", CW'(error), CW'(1));
`else
      chk("err_tied", CW'(error), CW'(0));
`endif
      fill_random();
      run_load(0, 1'b0, 1'b0);

      repeat (3) begin
         fill_random();
         run_load(2, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
